// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and constants for the UART TX arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } arb_state_e;

  localparam logic [7:0] BYTE_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - round-robin picker: first valid index after rr_ptr, wrapping mod N
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req_valid,
  input  logic [IDW-1:0] rr_ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  int best_d;
  int d;

  // Distance from rr_ptr+1 going upward with wrap; smallest distance wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + 2 * N - int'(rr_ptr) - 1) % N;
      if (req_valid[i] && (d < best_d)) begin
        best_d = d;
        any    = 1'b1;
        idx    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART TX core between N byte sources
// Optional line locking (no interleaving until LF) with UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic [IDW-1:0]   grant_id,
  output logic             active
`ifdef UART_ARB_LOCK_EN
  ,output logic            locked
`endif
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [N-1:0]   valid_m;
  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic [7:0]     pick_byte;
  logic           accept;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;

  always_comb begin
    valid_m = req_valid;
    if (lock_q) begin
      for (int i = 0; i < N; i++) begin
        valid_m[i] = req_valid[i] && (grant_id_q == IDW'(i));
      end
    end
  end

  assign locked = lock_q;
`else
  assign valid_m = req_valid;
`endif

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_valid (valid_m),
    .rr_ptr    (rr_ptr_q),
    .any       (pick_any),
    .idx       (pick_idx)
  );

  always_comb begin
    pick_byte = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == IDW'(i)) pick_byte = req_data[8*i +: 8];
    end
  end

  // req_ready is combinational so acceptance lands in the same cycle; rst masks it.
  assign accept = !rst && (state_q == ST_IDLE) && !tx_busy && pick_any;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = accept && (pick_idx == IDW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
`ifdef UART_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tx_data_d  = pick_byte;
          grant_id_d = pick_idx;
          rr_ptr_d   = pick_idx;
          state_d    = ST_ISSUE;
`ifdef UART_ARB_LOCK_EN
          lock_d     = 1'b1;
`endif
        end
      end
      ST_ISSUE:   state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (tx_busy) state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
`ifdef UART_ARB_LOCK_EN
          if (tx_data_q == BYTE_LF) lock_d = 1'b0;
`endif
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= IDW'(N - 1);
      tx_data_q  <= 8'h00;
      grant_id_q <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign tx_start = (state_q == ST_ISSUE);
  assign active   = (state_q != ST_IDLE);
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed table-driven bench for uart_tx_arbiter (N=2)
module tb_uart_tx_arbiter;

  localparam int N   = 2;
  localparam int IDW = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [IDW-1:0] grant_id;
  logic           active;
`ifdef UART_ARB_LOCK_EN
  logic           locked;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id)
`ifdef UART_ARB_LOCK_EN
    ,.locked   (locked)
`endif
    ,.active   (active)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [15:0] data;
    logic        busy;
    logic [1:0]  e_ready;
    logic        e_start;
    logic        e_active;
    logic        e_grant;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic [1:0] v, input logic [15:0] d, input logic b,
                     input logic [1:0] er, input logic es, input logic ea, input logic eg,
                     input logic [7:0] ed);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.busy = b;
    x.e_ready = er; x.e_start = es; x.e_active = ea; x.e_grant = eg; x.e_data = ed;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       seen_r1;
    int         starts;
    logic [1:0] pv;
    logic       pg;
    logic [7:0] pd;

    rst = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;

    // reset state + single requester, second byte after busy falls
    add(1, 2'b00, 16'h0000, 0, 2'b00, 0, 0, 0, 8'h00);
    add(0, 2'b01, 16'h0041, 0, 2'b01, 0, 0, 0, 8'h00);
    add(0, 2'b00, 16'h0041, 0, 2'b00, 1, 1, 0, 8'h41);
    add(0, 2'b00, 16'h0041, 1, 2'b00, 0, 1, 0, 8'h41);
    add(0, 2'b01, 16'h0042, 1, 2'b00, 0, 1, 0, 8'h41);
    add(0, 2'b01, 16'h0042, 0, 2'b00, 0, 1, 0, 8'h41);
    add(0, 2'b01, 16'h0042, 0, 2'b01, 0, 0, 0, 8'h41);
    add(0, 2'b00, 16'h0042, 0, 2'b00, 1, 1, 0, 8'h42);
    add(0, 2'b00, 16'h0042, 1, 2'b00, 0, 1, 0, 8'h42);
    add(0, 2'b00, 16'h0042, 0, 2'b00, 0, 1, 0, 8'h42);
    add(0, 2'b00, 16'h0042, 0, 2'b00, 0, 0, 0, 8'h42);
    // both requesters continuously valid: 30,31,30,31
    add(1, 2'b00, 16'h0000, 0, 2'b00, 0, 0, 0, 8'h00);
    pg = 1'b0; pd = 8'h00;
    for (int k = 0; k < 4; k++) begin
      logic       id;
      logic [7:0] by;
      id = k[0];
      by = 8'h30 + {7'd0, id};
      pv = id ? 2'b10 : 2'b01;
      add(0, 2'b11, 16'h3130, 0, pv,    0, 0, pg, pd);
      add(0, 2'b11, 16'h3130, 0, 2'b00, 1, 1, id, by);
      add(0, 2'b11, 16'h3130, 1, 2'b00, 0, 1, id, by);
      add(0, 2'b11, 16'h3130, 0, 2'b00, 0, 1, id, by);
      pg = id; pd = by;
    end
    // tx_busy high in IDLE blocks acceptance
    add(1, 2'b00, 16'h0000, 0, 2'b00, 0, 0, 0, 8'h00);
    add(0, 2'b10, 16'h5500, 1, 2'b00, 0, 0, 0, 8'h00);
    add(0, 2'b10, 16'h5500, 1, 2'b00, 0, 0, 0, 8'h00);
    add(0, 2'b10, 16'h5500, 0, 2'b10, 0, 0, 0, 8'h00);
    add(0, 2'b00, 16'h5500, 0, 2'b00, 1, 1, 1, 8'h55);
    add(0, 2'b00, 16'h5500, 1, 2'b00, 0, 1, 1, 8'h55);
    add(0, 2'b00, 16'h5500, 0, 2'b00, 0, 1, 1, 8'h55);
    add(0, 2'b00, 16'h5500, 0, 2'b00, 0, 0, 1, 8'h55);

    next_cycle();
    next_cycle();
    foreach (tbl[i]) begin
      rst = tbl[i].rst; req_valid = tbl[i].valid; req_data = tbl[i].data; tx_busy = tbl[i].busy;
      @(negedge clk);
      chk($sformatf("row%0d ready", i),  32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("row%0d start", i),  32'(tx_start),  32'(tbl[i].e_start));
      chk($sformatf("row%0d active", i), 32'(active),    32'(tbl[i].e_active));
      chk($sformatf("row%0d grant", i),  32'(grant_id),  32'(tbl[i].e_grant));
      chk($sformatf("row%0d data", i),   32'(tx_data),   32'(tbl[i].e_data));
      next_cycle();
    end

    // reset during WAIT_LO, then tie goes to requester 0
    rst = 1'b1; req_valid = '0; tx_busy = 1'b0;
    next_cycle();
    rst = 1'b0; req_valid = 2'b01; req_data = 16'h0077;
    @(negedge clk);
    chk("rstmid accept0", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    tx_busy = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rstmid active_wlo", 32'(active), 32'h1);
    rst = 1'b1; req_valid = 2'b11;
    #1;
    chk("rstmid start", 32'(tx_start), 32'h0);
    chk("rstmid ready", 32'(req_ready), 32'h0);
    chk("rstmid active", 32'(active), 32'h0);
    chk("rstmid data", 32'(tx_data), 32'h0);
    next_cycle();
    rst = 1'b0; tx_busy = 1'b0;
    @(negedge clk);
    chk("rstmid tie0", 32'(req_ready), 32'h1);
    next_cycle();

    // requester 1 withdraws while requester 0 is in flight
    rst = 1'b1; req_valid = '0;
    next_cycle();
    rst = 1'b0; req_valid = 2'b11; req_data = 16'h5B5A;
    @(negedge clk);
    chk("drop first", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = 2'b00;
    seen_r1 = 1'b0; starts = 0;
    for (int i = 0; i < 8; i++) begin
      tx_busy = (i == 1 || i == 2);
      @(negedge clk);
      if (req_ready[1]) seen_r1 = 1'b1;
      if (tx_start) starts++;
      next_cycle();
    end
    chk("drop no_ready1", 32'(seen_r1), 32'h0);
    chk("drop starts", 32'(starts), 32'd1);
    chk("drop idle", 32'(active), 32'h0);

`ifdef UART_ARB_LOCK_EN
    begin
      logic [7:0] line0[3];
      logic [7:0] got[$];
      int         p0, bcnt;
      logic       done1;
      logic       lk_ok;
      line0[0] = 8'h48; line0[1] = 8'h49; line0[2] = 8'h0A;
      rst = 1'b1; req_valid = '0; tx_busy = 1'b0;
      next_cycle();
      rst = 1'b0; p0 = 0; done1 = 1'b0; bcnt = 0; lk_ok = 1'b1;
      for (int c = 0; c < 80; c++) begin
        req_valid = {!done1, p0 < 3};
        req_data  = {8'h5A, (p0 < 3) ? line0[p0] : 8'h00};
        tx_busy   = (bcnt != 0);
        if (bcnt > 0) bcnt--;
        @(negedge clk);
        if (tx_start) begin
          got.push_back(tx_data);
          bcnt = 3;
          if (tx_data != 8'h5A && !locked) lk_ok = 1'b0;
        end
        if (req_ready[0]) p0++;
        if (req_ready[1]) done1 = 1'b1;
        next_cycle();
      end
      chk("lock count", 32'(got.size()), 32'd4);
      if (got.size() == 4) begin
        chk("lock b0", 32'(got[0]), 32'h48);
        chk("lock b1", 32'(got[1]), 32'h49);
        chk("lock b2", 32'(got[2]), 32'h0A);
        chk("lock b3", 32'(got[3]), 32'h5A);
      end
      chk("lock held", 32'(lk_ok), 32'h1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter behind serial_txd between N byte sources, e.g. the 6502 debug/print port and the LED/status reporter.
- Each source has a valid/ready byte handshake. The block picks sources round-robin, hands one byte at a time to the TX core, and sequences the core's start/busy handshake.
- Sits between the requesters and the uart_tx core inside the UART top level.

Parameters:
- N, 2, number of requesters (2..8).
- IDW, 1, width of grant_id; must equal clog2(N), minimum 1.

Ports:
- clk  in  1  system clock (12 MHz board clock).
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N  requester i has a byte pending.
- req_data  in  8*N  byte of requester i in bits [8i+7:8i].
- req_ready  out  N  one-hot pulse; byte of requester i accepted this cycle.
- tx_start  out  1  one-cycle start strobe to the TX core.
- tx_data  out  8  byte to the TX core; stable from tx_start until tx_busy falls.
- tx_busy  in  1  TX core busy; rises the cycle after tx_start, falls when the stop bit completes.
- grant_id  out  IDW  index of the requester owning the current/last byte.
- active  out  1  high while a byte is in flight (any state other than IDLE).

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, state=IDLE, rr_ptr=N-1 (so requester 0 has first priority).
- IDLE:
  - If tx_busy=0 and any req_valid: pick the first valid index searching rr_ptr+1, rr_ptr+2, ... with wrap modulo N.
  - In that cycle: pulse req_ready[i]=1, latch tx_data=req_data[i], grant_id=i, rr_ptr=i; next state ISSUE.
  - If tx_busy=1: accept nothing.
- ISSUE: tx_start=1 for exactly one cycle, active=1; next state WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. No timeout; the core guarantees busy the cycle after start.
- WAIT_LO: wait for tx_busy=0, then go to IDLE.
- Throughput: back-to-back bytes have 2 idle cycles between tx_busy falling and the next tx_start (IDLE accept + ISSUE).
- Latency: req_valid high in IDLE gives req_ready the same cycle and tx_start the next cycle.
- Handshake:
  - Requester holds req_valid/req_data until req_ready is seen. Dropping req_valid before ready is legal; the request is simply not served.
  - req_ready is never asserted outside IDLE.
  - At most one req_ready bit is high per cycle.
- Fairness: with all N requesters continuously valid, grants cycle 0,1,...,N-1,0,...
- A lone requester is granted every byte.
- Reset mid-operation: all outputs return to reset values immediately; the in-flight byte is abandoned.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- Defined:
  - After granting requester i, arbitration is locked to i until a byte equal to 8'h0A (LF) from i completes, so text lines never interleave.
  - While locked, IDLE accepts only from i; other requesters wait even if valid.
  - Output locked (1 bit, reset 0) is added.
- Undefined: pure per-byte round-robin; no locked port.

Decomposition:
- Package uart_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT_HI=2'd2, ST_WAIT_LO=2'd3.
  - BYTE_LF=8'h0A.
- One combinational sub-module, rr_pick: inputs req_valid[N] and rr_ptr; outputs any and idx. It is isolated so it can be tested exhaustively.

Test Plan:
- Reset, then only req_valid[0] with data 8'h41 -> req_ready[0] pulse, tx_start one cycle later with tx_data=8'h41 and grant_id=0; second 8'h42 is accepted 2 cycles after tx_busy falls.
- N=2, both valid continuously (0:8'h30, 1:8'h31) -> tx_data sequence 30,31,30,31; grants alternate starting with 0.
- tx_busy forced high while req_valid[1]=1 in IDLE -> no req_ready until tx_busy=0, then req_ready[1] the same cycle.
- rst asserted during WAIT_LO -> tx_start, req_ready and active are 0 immediately; after release, requester 0 wins ties.
- Requester 1 drops req_valid while requester 0's byte is in flight -> requester 1 is never served and req_ready[1] stays 0.
- With UART_ARB_LOCK_EN: requester 0 sends "HI\n" (48,49,0A) while requester 1 is valid with 8'h5A -> 5A transmitted only after 0A; locked high from the 48 grant until 0A completes.
